// File: rtl/alarm_countdown_fsm_pkg.sv
// alarm_countdown_fsm_pkg: shared state encoding, digit width and default second counts
package alarm_countdown_fsm_pkg;
  typedef enum logic [2:0] {
    ARMED     = 3'd0,
    TRIGGERED = 3'd1,
    ALARM     = 3'd2,
    DISARMED  = 3'd3,
    DOOR_OPEN = 3'd4,
    ARM_WAIT  = 3'd5
  } state_e;
  localparam int DIGIT_W         = 4;
  localparam int DEF_CLK_HZ      = 100_000_000;
  localparam int DEF_T_ARM_DELAY = 6;
  localparam int DEF_T_DRIVER    = 8;
  localparam int DEF_T_PASSENGER = 15;
  localparam int DEF_T_ALARM     = 10;
endpackage

// File: rtl/alarm_countdown_fsm_sec_tick_gen.sv
// sec_tick_gen: one-cycle tick every CLK_HZ cycles, restartable by clr
module sec_tick_gen
  import alarm_countdown_fsm_pkg::*;
#(
  parameter int CLK_HZ = DEF_CLK_HZ
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);
  localparam int W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [W-1:0] LAST = W'(CLK_HZ - 1);
  logic [W-1:0] div_q, div_d;
  assign tick = (div_q == LAST);
  // divider wraps after the tick; a clear restarts the second so a fresh load gets full seconds
  always_comb begin
    div_d = (clr || tick) ? '0 : div_q + 1'b1;
  end
  // divider register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) div_q <= '0;
    else        div_q <= div_d;
  end
endmodule

// File: rtl/alarm_countdown_fsm.sv
// alarm_countdown_fsm: anti-theft state machine with second countdowns, siren, led and fuel-pump latch
module alarm_countdown_fsm
  import alarm_countdown_fsm_pkg::*;
#(
  parameter int CLK_HZ      = DEF_CLK_HZ,
  parameter int T_ARM_DELAY = DEF_T_ARM_DELAY,
  parameter int T_DRIVER    = DEF_T_DRIVER,
  parameter int T_PASSENGER = DEF_T_PASSENGER,
  parameter int T_ALARM     = DEF_T_ALARM
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ignition,
  input  logic               door_driver,
  input  logic               door_pass,
  input  logic               hidden_sw,
  input  logic               brake,
  output logic [DIGIT_W-1:0] digit,
  output logic [2:0]         state_code,
  output logic               status_led,
  output logic               siren,
  output logic               fuel_pump
);
  localparam logic [DIGIT_W-1:0] LD_ARM = DIGIT_W'(T_ARM_DELAY);
  localparam logic [DIGIT_W-1:0] LD_DRV = DIGIT_W'(T_DRIVER);
  localparam logic [DIGIT_W-1:0] LD_PAS = DIGIT_W'(T_PASSENGER);
  localparam logic [DIGIT_W-1:0] LD_ALM = DIGIT_W'(T_ALARM);
  state_e state_q, state_d;
  logic [DIGIT_W-1:0] cnt_q, cnt_d;
  logic led_q, led_d, siren_q, siren_d, fuel_q, fuel_d;
  logic tick, clr, expire;
  sec_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .tick  (tick)
  );
  assign expire     = tick && (cnt_q == DIGIT_W'(1));
  assign digit      = cnt_q;
  assign state_code = state_q;
  assign status_led = led_q;
  assign siren      = siren_q;
  assign fuel_pump  = fuel_q;
  // next state, countdown load/decrement and registered output values
  always_comb begin
    state_d = state_q;
    cnt_d   = (tick && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    clr     = 1'b0;
    case (state_q)
      ARMED: begin
        cnt_d = '0;
        if (ignition) state_d = DISARMED;
        else if (door_driver) begin
          state_d = TRIGGERED;
          cnt_d   = LD_DRV;
          clr     = 1'b1;
        end else if (door_pass) begin
          state_d = TRIGGERED;
          cnt_d   = LD_PAS;
          clr     = 1'b1;
        end
      end
      TRIGGERED: begin
        if (ignition) begin
          state_d = DISARMED;
          cnt_d   = '0;
        end else if (expire) begin
          state_d = ALARM;
          cnt_d   = LD_ALM;
          clr     = 1'b1;
        end
      end
      ALARM: begin
        if (ignition) begin
          state_d = DISARMED;
          cnt_d   = '0;
        end else if (door_driver || door_pass) begin
          cnt_d = LD_ALM;
          clr   = 1'b1;
        end else if (expire) state_d = ARMED;
      end
      DISARMED: begin
        cnt_d = '0;
        if (!ignition && door_driver) state_d = DOOR_OPEN;
      end
      DOOR_OPEN: begin
        cnt_d = '0;
        if (ignition) state_d = DISARMED;
        else if (!door_driver) begin
          state_d = ARM_WAIT;
          cnt_d   = LD_ARM;
          clr     = 1'b1;
        end
      end
      ARM_WAIT: begin
        if (ignition) begin
          state_d = DISARMED;
          cnt_d   = '0;
        end else if (door_driver || door_pass) begin
          state_d = DOOR_OPEN;
          cnt_d   = '0;
        end else if (expire) state_d = ARMED;
      end
      default: begin
        state_d = ARMED;
        cnt_d   = '0;
      end
    endcase
    led_d   = (state_d == ARMED) ? (state_q == ARMED) && (led_q ^ tick)
                                 : (state_d == TRIGGERED) || (state_d == ALARM);
    siren_d = (state_d == ALARM);
    fuel_d  = ignition && ((hidden_sw && brake) || fuel_q);
  end
  // state, countdown and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARMED;
      cnt_q   <= '0;
      led_q   <= 1'b0;
      siren_q <= 1'b0;
      fuel_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      led_q   <= led_d;
      siren_q <= siren_d;
      fuel_q  <= fuel_d;
    end
  end
endmodule

// File: tb/tb_alarm_countdown_fsm.sv
// tb_alarm_countdown_fsm: directed vectors and multi-cycle sequences with CLK_HZ=4
module tb_alarm_countdown_fsm;
  import alarm_countdown_fsm_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0;
  logic ignition = 0, door_driver = 0, door_pass = 0, hidden_sw = 0, brake = 0;
  logic [3:0] digit;
  logic [2:0] state_code;
  logic status_led, siren, fuel_pump;
  int total = 0, bad = 0;

  typedef struct packed {
    logic ign, dd, dp, hs, br;
    logic [2:0] st;
    logic [3:0] dig;
    logic led, sir, fuel;
  } vec_t;
  vec_t vecs [15];

  alarm_countdown_fsm #(.CLK_HZ(4)) dut (
    .clk(clk), .rst_n(rst_n), .ignition(ignition), .door_driver(door_driver),
    .door_pass(door_pass), .hidden_sw(hidden_sw), .brake(brake), .digit(digit),
    .state_code(state_code), .status_led(status_led), .siren(siren), .fuel_pump(fuel_pump)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [2:0] st, input logic [3:0] dig,
                     input logic led, input logic sir, input logic fuel);
    total++;
    if ({state_code, digit, status_led, siren, fuel_pump} !== {st, dig, led, sir, fuel}) begin
      bad++;
      $display("FAIL %s: got st=%0d dig=%0d led=%b siren=%b fuel=%b, want st=%0d dig=%0d led=%b siren=%b fuel=%b",
               name, state_code, digit, status_led, siren, fuel_pump, st, dig, led, sir, fuel);
    end
  endtask

  task automatic step(input logic ign, input logic dd, input logic dp, input logic hs, input logic br);
    ignition = ign; door_driver = dd; door_pass = dp; hidden_sw = hs; brake = br;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'd3, 4'd0, 1'b0, 1'b0, 1'b1};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 4'd0, 1'b0, 1'b0, 1'b1};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd3, 4'd0, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 4'd0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd3, 4'd0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd3, 4'd0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 4'd0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'd3, 4'd0, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd4, 4'd0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd3, 4'd0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 4'd0, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd4, 4'd0, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd5, 4'd6, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd4, 4'd0, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 4'd0, 1'b0, 1'b0, 1'b0};

    #12;
    chk("reset", 3'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      step(0, 0, 0, 0, 0);
      chk($sformatf("idle%0d", k), 3'd0, 4'd0, 1'((k / 4) % 2), 1'b0, 1'b0);
    end

    step(0, 0, 1, 0, 0);
    chk("pass_load", 3'd1, 4'd15, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 59; i++) begin
      step(0, 0, 1, 0, 0);
      chk($sformatf("trig_pass%0d", i), 3'd1, 4'(15 - i / 4), 1'b1, 1'b0, 1'b0);
    end
    step(0, 0, 1, 0, 0);
    chk("alarm_enter", 3'd2, 4'd10, 1'b1, 1'b1, 1'b0);
    for (int i = 1; i <= 6; i++) begin
      step(0, 0, 1, 0, 0);
      chk($sformatf("alarm_hold%0d", i), 3'd2, 4'd10, 1'b1, 1'b1, 1'b0);
    end
    for (int i = 1; i <= 40; i++) begin
      step(0, 0, 0, 0, 0);
      if (i < 40) chk($sformatf("alarm_cnt%0d", i), 3'd2, 4'(10 - i / 4), 1'b1, 1'b1, 1'b0);
      else        chk("alarm_expire", 3'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    end

    step(0, 1, 0, 0, 0);
    chk("drv_load", 3'd1, 4'd8, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      step(0, 0, 0, 0, 0);
      chk($sformatf("trig_drv%0d", i), 3'd1, 4'(8 - i / 4), 1'b1, 1'b0, 1'b0);
    end
    step(1, 0, 0, 0, 0);
    chk("trig_ign", 3'd3, 4'd0, 1'b0, 1'b0, 1'b0);

    step(0, 1, 0, 0, 0);
    chk("door_open", 3'd4, 4'd0, 1'b0, 1'b0, 1'b0);
    step(0, 0, 0, 0, 0);
    chk("arm_wait_load", 3'd5, 4'd6, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 12; i++) begin
      step(0, 0, 0, 0, 0);
      chk($sformatf("arm_wait%0d", i), 3'd5, 4'(6 - i / 4), 1'b0, 1'b0, 1'b0);
    end
    step(0, 1, 0, 0, 0);
    chk("arm_wait_reopen", 3'd4, 4'd0, 1'b0, 1'b0, 1'b0);
    step(0, 0, 0, 0, 0);
    chk("arm_wait_reload", 3'd5, 4'd6, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 24; i++) begin
      step(0, 0, 0, 0, 0);
      if (i < 24) chk($sformatf("arm_wait2_%0d", i), 3'd5, 4'(6 - i / 4), 1'b0, 1'b0, 1'b0);
      else        chk("armed_again", 3'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    end

    for (int v = 0; v < 15; v++) begin
      step(vecs[v].ign, vecs[v].dd, vecs[v].dp, vecs[v].hs, vecs[v].br);
      chk($sformatf("vec%0d", v), vecs[v].st, vecs[v].dig, vecs[v].led, vecs[v].sir, vecs[v].fuel);
    end

    ignition = 0; door_driver = 0; door_pass = 0; hidden_sw = 0; brake = 0;
    rst_n = 1'b0;
    #1;
    chk("rst2", 3'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step(0, 1, 1, 0, 0);
    chk("both_doors", 3'd1, 4'd8, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 32; i++) step(0, 0, 0, 0, 0);
    chk("alarm_closed_entry", 3'd2, 4'd10, 1'b1, 1'b1, 1'b0);
    for (int i = 1; i <= 12; i++) step(0, 0, 0, 0, 0);
    chk("alarm_at7", 3'd2, 4'd7, 1'b1, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst", 3'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    #1;
    rst_n = 1'b1;
    dut.state_q = state_e'(3'd6);
    #1;
    chk("illegal_forced", 3'd6, 4'd0, 1'b0, 1'b0, 1'b0);
    step(0, 0, 0, 0, 0);
    chk("illegal_recover", 3'd0, 4'd0, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
